// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared constants, state encoding and timeout helper for the UART frame parser
package uart_frame_pkg;

   localparam logic [7:0] HDR0  = 8'h55;
   localparam logic [7:0] HDR1  = 8'hAA;
   localparam int         LEN_W = 5;

   typedef enum logic [5:0] {
      S_H0   = 6'b000001,
      S_H1   = 6'b000010,
      S_CMD  = 6'b000100,
      S_LEN  = 6'b001000,
      S_DATA = 6'b010000,
      S_CSUM = 6'b100000
   } state_t;

   function automatic int timeout_clks(input int clock, input int baud, input int bits);
      return (clock / baud) * bits;
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte gap counter; expires on the cycle the count reaches LIMIT-1
module uart_frame_timer #(
   parameter int LIMIT = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_cnt;

   // A byte on the expiry cycle wins, so a clear masks expiry
   assign o_expire = i_en && !i_clr && (r_cnt == W'(LIMIT - 1));

   // Count idle clocks while enabled; restart on every byte, when disabled or after expiry
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else     r_cnt <= (i_clr || !i_en || o_expire) ? '0 : r_cnt + W'(1);

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts 55 AA CMD LEN PAYLOAD CSUM frames in a UART byte stream; FRAME_TIMEOUT_EN adds an inter-byte gap timeout
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int CLOCK        = 50_000_000,
   parameter int BAUD         = 9600,
   parameter int MAX_LEN      = 8,
   parameter int TIMEOUT_BITS = 30
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_data_vld,
   output logic                   frame_vld,
   output logic [7:0]             frame_cmd,
   output logic [LEN_W-1:0]       frame_len,
   output logic [MAX_LEN*8-1:0]   frame_data,
   output logic                   err_csum,
   output logic                   err_len,
   output logic                   err_timeout
);

   localparam int         TO_CLKS   = timeout_clks(CLOCK, BAUD, TIMEOUT_BITS);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   if (MAX_LEN < 1 || MAX_LEN > 16 || TO_CLKS < 2) begin : g_bad_param
      $error("uart_frame_parser: MAX_LEN must be 1..16 and the timeout at least 2 clocks");
   end

   state_t               r_state, w_next;
   logic [7:0]           r_cmd, r_sum;
   logic [LEN_W-1:0]     r_len, r_idx;
   logic [MAX_LEN*8-1:0] r_buf;
   logic                 w_good, w_bad_csum, w_bad_len, w_expire;

`ifdef FRAME_TIMEOUT_EN
   uart_frame_timer #(.LIMIT(TO_CLKS)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (rx_data_vld),
      .i_en     (r_state != S_H0),
      .o_expire (w_expire)
   );

   // Timeout strobe lags the expiry cycle by one clock, like the other strobes
   always_ff @(posedge clk or posedge rst)
      if (rst) err_timeout <= 1'b0;
      else     err_timeout <= w_expire;
`else
   assign w_expire    = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_H0;
      else     r_state <= w_next;

   // Next state and frame verdicts; only a received byte or a timeout moves the FSM
   always_comb begin
      w_next     = r_state;
      w_good     = 1'b0;
      w_bad_csum = 1'b0;
      w_bad_len  = 1'b0;
      if (rx_data_vld) begin
         case (r_state)
            S_H0:   w_next = (rx_data == HDR0) ? S_H1 : S_H0;
            S_H1:   w_next = (rx_data == HDR1) ? S_CMD : (rx_data == HDR0) ? S_H1 : S_H0;
            S_CMD:  w_next = S_LEN;
            S_LEN: begin
               w_bad_len = rx_data > MAX_LEN_B;
               w_next    = w_bad_len ? S_H0 : (rx_data == 8'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: w_next = (r_idx == r_len - LEN_W'(1)) ? S_CSUM : S_DATA;
            S_CSUM: begin
               w_good     = rx_data == r_sum;
               w_bad_csum = !w_good;
               w_next     = S_H0;
            end
            default: w_next = S_H0;
         endcase
      end else if (w_expire) begin
         w_next = S_H0;
      end
   end

   // Shadow frame: cmd, len, payload and running checksum over CMD, LEN and payload
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cmd <= '0;
         r_len <= '0;
         r_idx <= '0;
         r_sum <= '0;
         r_buf <= '0;
      end else if (rx_data_vld) begin
         if (r_state == S_CMD) begin
            r_cmd <= rx_data;
            r_sum <= rx_data;
         end
         if (r_state == S_LEN && !w_bad_len) begin
            r_len <= rx_data[LEN_W-1:0];
            r_sum <= r_sum + rx_data;
            r_buf <= '0;
            r_idx <= '0;
         end
         if (r_state == S_DATA) begin
            for (int i = 0; i < MAX_LEN; i++)
               if (r_idx == LEN_W'(i)) r_buf[i*8 +: 8] <= rx_data;
            r_sum <= r_sum + rx_data;
            r_idx <= r_idx + LEN_W'(1);
         end
      end

   // Registered strobes; the visible frame only changes on a good checksum
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         frame_vld  <= 1'b0;
         err_csum   <= 1'b0;
         err_len    <= 1'b0;
         frame_cmd  <= '0;
         frame_len  <= '0;
         frame_data <= '0;
      end else begin
         frame_vld <= w_good;
         err_csum  <= w_bad_csum;
         err_len   <= w_bad_len;
         if (w_good) begin
            frame_cmd  <= r_cmd;
            frame_len  <= r_len;
            frame_data <= r_buf;
         end
      end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed self-checking bench for uart_frame_parser (MAX_LEN=8, timeout = 30 clocks when FRAME_TIMEOUT_EN is defined)
module tb_uart_frame_parser;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_data_vld = 1'b0;
   logic        frame_vld, err_csum, err_len, err_timeout;
   logic [7:0]  frame_cmd;
   logic [4:0]  frame_len;
   logic [63:0] frame_data;

   int n_chk = 0, n_fail = 0;
   int n_vld = 0, n_csum = 0, n_len = 0, n_to = 0;
   int exp_vld = 0, exp_csum = 0, exp_len = 0, exp_to = 0;
   int k;

   uart_frame_parser #(
      .CLOCK(1000), .BAUD(100), .MAX_LEN(8), .TIMEOUT_BITS(3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_data_vld (rx_data_vld),
      .frame_vld   (frame_vld),
      .frame_cmd   (frame_cmd),
      .frame_len   (frame_len),
      .frame_data  (frame_data),
      .err_csum    (err_csum),
      .err_len     (err_len),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   // Strobe tally, sampled mid-cycle
   always @(negedge clk) begin
      if (frame_vld)   n_vld++;
      if (err_csum)    n_csum++;
      if (err_len)     n_len++;
      if (err_timeout) n_to++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data     = b;
      rx_data_vld = 1'b1;
      @(posedge clk);
      #1;
      rx_data_vld = 1'b0;
   endtask

   task automatic send_seq(input bq_t q);
      foreach (q[i]) send(q[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] cmd, input logic [4:0] len, input logic [63:0] data);
      exp_vld++;
      check({tag, "_vld"},  {63'd0, frame_vld}, 64'd1);
      check({tag, "_cmd"},  {56'd0, frame_cmd}, {56'd0, cmd});
      check({tag, "_len"},  {59'd0, frame_len}, {59'd0, len});
      check({tag, "_data"}, frame_data, data);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_strobes"}, {60'd0, frame_vld, err_csum, err_len, err_timeout}, 64'd0);
      check({tag, "_cmd"},  {56'd0, frame_cmd}, 64'd0);
      check({tag, "_len"},  {59'd0, frame_len}, 64'd0);
      check({tag, "_data"}, frame_data, 64'd0);
   endtask

   initial begin
      idle(2);
      chk_zero("reset");
      rst = 1'b0;
      idle(2);

      // Bad checksum, then the same frame with the right checksum (sum wraps 0x165 -> 0x65)
      send_seq('{8'h55, 8'hAA, 8'h10, 8'h02, 8'hA1, 8'hB2, 8'h63});
      exp_csum++;
      check("csum_err", {63'd0, err_csum}, 64'd1);
      check("csum_err_novld", {63'd0, frame_vld}, 64'd0);
      check("csum_err_cmd", {56'd0, frame_cmd}, 64'd0);
      check("csum_err_data", frame_data, 64'd0);
      idle(1);
      check("csum_err_1clk", {63'd0, err_csum}, 64'd0);
      send_seq('{8'h55, 8'hAA, 8'h10, 8'h02, 8'hA1, 8'hB2, 8'h65});
      chk_frame("f10", 8'h10, 5'd2, 64'h0000_0000_0000_B2A1);
      idle(1);
      check("f10_vld_1clk", {63'd0, frame_vld}, 64'd0);
      check("f10_hold", frame_data, 64'h0000_0000_0000_B2A1);

      // Zero-length frame
      send_seq('{8'h55, 8'hAA, 8'h07, 8'h00, 8'h07});
      chk_frame("len0", 8'h07, 5'd0, 64'd0);

      // Over-length LEN, then a good frame
      send_seq('{8'h55, 8'hAA, 8'h01, 8'h09});
      exp_len++;
      check("len_err", {63'd0, err_len}, 64'd1);
      check("len_err_keep_cmd", {56'd0, frame_cmd}, 64'h07);
      send_seq('{8'h55, 8'hAA, 8'h03, 8'h01, 8'h44, 8'h48});
      chk_frame("after_len", 8'h03, 5'd1, 64'h44);

      // Noise and resync on repeated 0x55
      send_seq('{8'hFF, 8'h55, 8'h55, 8'hAA, 8'h20, 8'h01, 8'h5A, 8'h7B});
      chk_frame("resync", 8'h20, 5'd1, 64'h5A);

      // Back-to-back frames with no idle bytes
      send_seq('{8'h55, 8'hAA, 8'h31, 8'h01, 8'h11, 8'h43});
      chk_frame("b2b_a", 8'h31, 5'd1, 64'h11);
      send_seq('{8'h55, 8'hAA, 8'h32, 8'h02, 8'h01, 8'h02, 8'h37});
      chk_frame("b2b_b", 8'h32, 5'd2, 64'h0201);

      // 0x55 in the checksum slot must not start a new frame
      send_seq('{8'h55, 8'hAA, 8'h40, 8'h00, 8'h55});
      exp_csum++;
      check("csum55_err", {63'd0, err_csum}, 64'd1);
      send_seq('{8'hAA, 8'h41, 8'h00, 8'h41});
      idle(1);
      check("csum55_no_hdr", {32'd0, 32'(n_vld)}, {32'd0, 32'(exp_vld)});

      // Maximum length, then a shorter frame whose upper payload must read 0
      send_seq('{8'h55, 8'hAA, 8'h09, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h35});
      chk_frame("maxlen", 8'h09, 5'd8, 64'h0807_0605_0403_0201);
      send_seq('{8'h55, 8'hAA, 8'h0A, 8'h01, 8'h77, 8'h82});
      chk_frame("short", 8'h0A, 5'd1, 64'h77);

      // Asynchronous reset in the middle of a payload
      send_seq('{8'h55, 8'hAA, 8'h50, 8'h03, 8'h01});
      #1 rst = 1'b1;
      #1 chk_zero("midreset");
      idle(1);
      rst = 1'b0;
      send_seq('{8'h55, 8'hAA, 8'h60, 8'h01, 8'h22, 8'h83});
      chk_frame("post_reset", 8'h60, 5'd1, 64'h22);

`ifdef FRAME_TIMEOUT_EN
      // Stall after CMD: timeout 30 clocks after the last byte
      send_seq('{8'h55, 8'hAA, 8'h05});
      k = 0;
      while (!err_timeout && k < 40) begin
         idle(1);
         k++;
      end
      exp_to++;
      check("to_cycles", 64'(k), 64'd30);
      send_seq('{8'h55, 8'hAA, 8'h06, 8'h00, 8'h06});
      chk_frame("after_to", 8'h06, 5'd0, 64'd0);
      // Byte on the expiry cycle wins
      send_seq('{8'h55, 8'hAA, 8'h05});
      idle(29);
      send(8'h01);
      check("to_byte_wins", {63'd0, err_timeout}, 64'd0);
      send_seq('{8'h33, 8'h39});
      chk_frame("to_edge", 8'h05, 5'd1, 64'h33);
`else
      // Without the timeout a stalled frame simply resumes
      send_seq('{8'h55, 8'hAA, 8'h05});
      idle(40);
      check("no_to", {63'd0, err_timeout}, 64'd0);
      send_seq('{8'h01, 8'h33, 8'h39});
      chk_frame("stall", 8'h05, 5'd1, 64'h33);
`endif

      idle(2);
      check("cnt_vld",  64'(n_vld),  64'(exp_vld));
      check("cnt_csum", 64'(n_csum), 64'(exp_csum));
      check("cnt_len",  64'(n_len),  64'(exp_len));
      check("cnt_to",   64'(n_to),   64'(exp_to));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
